score_keeper: RTL and testbench

- Parametrised N-lane scoring unit for the rhythm game.
- Edge-detects per-lane hit/miss flags from the pattern lanes, maintains a combo counter and a score multiplier, and accumulates a saturating score.
- Converts the score to packed BCD with a sequential double-dabble engine that feeds the placar display.
- Runs on the pixel clock domain, alongside the pattern lanes.

---
 rtl/score_keeper.sv | 198 +++++++++++++++++++
 tb/tb_score_keeper.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: N-lane hit/miss scoring with combo multiplier, saturating score and a
// sequential double-dabble BCD converter. Optional high-score tracking: SCORE_KEEPER_HISCORE_EN.

module score_lane (
  input  logic CLOCK_25,
  input  logic rst,
  input  logic hit,
  input  logic miss,
  output logic hit_ev,
  output logic miss_ev
);
  logic hit_prev, miss_prev;

  // prev resets high so a flag already asserted at reset release is not an event
  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      hit_prev  <= 1'b1;
      miss_prev <= 1'b1;
    end else begin
      hit_prev  <= hit;
      miss_prev <= miss;
    end
  end

  assign miss_ev = miss & ~miss_prev;
  assign hit_ev  = hit & ~hit_prev & ~miss_ev;
endmodule

module score_keeper #(
  parameter int N_LANES    = 8,
  parameter int SCORE_W    = 16,
  parameter int COMBO_W    = 8,
  parameter int COMBO_STEP = 10,
  parameter int MAX_MULT   = 4,
  parameter int BCD_DIGITS = 5
) (
  input  logic                          CLOCK_25,
  input  logic                          rst,
  input  logic                          restart,
  input  logic                          game_over,
  input  logic [N_LANES-1:0]            hit,
  input  logic [N_LANES-1:0]            miss,
  output logic [SCORE_W-1:0]            score,
  output logic [COMBO_W-1:0]            combo,
  output logic [$clog2(MAX_MULT+1)-1:0] mult,
  output logic [4*BCD_DIGITS-1:0]       bcd,
  output logic                          bcd_valid
`ifdef SCORE_KEEPER_HISCORE_EN
  ,
  output logic [SCORE_W-1:0]            hiscore,
  output logic                          new_record
`endif
);
  localparam int MW = $clog2(MAX_MULT+1);
  localparam int NW = $clog2(N_LANES+1);
  localparam int SW = SCORE_W + NW + MW + 1;
  localparam int CW = COMBO_W + NW + 1;
  localparam int BW = 4*BCD_DIGITS;
  localparam int KW = $clog2(SCORE_W+1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [N_LANES-1:0] hit_ev, miss_ev;
  logic [NW-1:0]      nh, nm;
  logic [SW-1:0]      score_sum;
  logic [CW-1:0]      combo_sum;
  logic [SCORE_W-1:0] score_ev, score_d;
  logic [COMBO_W-1:0] combo_ev, combo_d, steps;
  logic [MW-1:0]      mult_ev, mult_d;
  logic               score_chg;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    score_lane u_lane (
      .CLOCK_25 (CLOCK_25),
      .rst      (rst),
      .hit      (hit[i]),
      .miss     (miss[i]),
      .hit_ev   (hit_ev[i]),
      .miss_ev  (miss_ev[i])
    );
  end

  always_comb begin
    nh = '0;
    nm = '0;
    for (int i = 0; i < N_LANES; i++) begin
      nh = nh + NW'(hit_ev[i]);
      nm = nm + NW'(miss_ev[i]);
    end
    // points use the multiplier registered before this cycle's update
    score_sum = SW'(score) + SW'(nh) * SW'(mult);
    score_ev  = (score_sum > SW'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    combo_sum = CW'(combo) + CW'(nh);
    if (nm != '0) combo_ev = '0;
    else          combo_ev = (combo_sum > CW'(COMBO_MAX)) ? COMBO_MAX : combo_sum[COMBO_W-1:0];
    steps   = combo_ev / COMBO_W'(COMBO_STEP);
    mult_ev = (steps >= COMBO_W'(MAX_MULT-1)) ? MW'(MAX_MULT) : MW'(steps) + MW'(1);
    if (restart) begin
      score_d = '0;
      combo_d = '0;
      mult_d  = MW'(1);
    end else if (game_over) begin
      score_d = score;
      combo_d = combo;
      mult_d  = mult;
    end else begin
      score_d = score_ev;
      combo_d = combo_ev;
      mult_d  = mult_ev;
    end
    score_chg = (score_d != score);
  end

  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      score <= '0;
      combo <= '0;
      mult  <= MW'(1);
    end else begin
      score <= score_d;
      combo <= combo_d;
      mult  <= mult_d;
    end
  end

  state_t             state;
  logic               chg_q, pending;
  logic [SCORE_W-1:0] bin_sr;
  logic [BW-1:0]      bcd_sr, bcd_adj;
  logic [KW-1:0]      cnt;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < BCD_DIGITS; d++)
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
  end

  // chg_q delays the change by one edge so IDLE reacts to the registered score
  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      chg_q     <= 1'b0;
      pending   <= 1'b0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      cnt       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else begin
      chg_q <= score_chg;
      case (state)
        IDLE:  if (chg_q || pending) state <= LOAD;
        LOAD: begin
          bin_sr  <= score;
          bcd_sr  <= '0;
          cnt     <= KW'(SCORE_W-1);
          pending <= chg_q;
          state   <= SHIFT;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[BW-2:0], bin_sr, 1'b0};
          cnt <= cnt - KW'(1);
          if (chg_q) pending <= 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          bcd <= bcd_sr;
          if (chg_q) pending <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (score_chg) bcd_valid <= 1'b0;
      else if (state == DONE && !pending && !chg_q) bcd_valid <= 1'b1;
    end
  end

`ifdef SCORE_KEEPER_HISCORE_EN
  logic game_over_q;

  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      game_over_q <= 1'b0;
      hiscore     <= '0;
      new_record  <= 1'b0;
    end else begin
      game_over_q <= game_over;
      new_record  <= 1'b0;
      if (game_over && !game_over_q && score > hiscore) begin
        hiscore    <= score;
        new_record <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: default instance plus a narrow (SCORE_W=8, COMBO_W=4) instance,
// both compared every cycle against a plain-arithmetic model, plus directed literal checks.

module tb_score_keeper;
  logic       clk = 1'b0;
  logic       rst_n, restart, game_over;
  logic [7:0] hit, miss;

  logic [15:0] a_score;  logic [7:0] a_combo;  logic [2:0] a_mult;
  logic [19:0] a_bcd;    logic       a_valid;
  logic [7:0]  b_score;  logic [3:0] b_combo;  logic [2:0] b_mult;
  logic [11:0] b_bcd;    logic       b_valid;
`ifdef SCORE_KEEPER_HISCORE_EN
  logic [15:0] a_hs;  logic a_nr;
  logic [7:0]  b_hs;  logic b_nr;
`endif

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  score_keeper u_a (
    .CLOCK_25(clk), .rst(rst_n), .restart(restart), .game_over(game_over),
    .hit(hit), .miss(miss), .score(a_score), .combo(a_combo), .mult(a_mult),
    .bcd(a_bcd), .bcd_valid(a_valid)
`ifdef SCORE_KEEPER_HISCORE_EN
    , .hiscore(a_hs), .new_record(a_nr)
`endif
  );

  score_keeper #(.SCORE_W(8), .COMBO_W(4), .BCD_DIGITS(3)) u_b (
    .CLOCK_25(clk), .rst(rst_n), .restart(restart), .game_over(game_over),
    .hit(hit), .miss(miss), .score(b_score), .combo(b_combo), .mult(b_mult),
    .bcd(b_bcd), .bcd_valid(b_valid)
`ifdef SCORE_KEEPER_HISCORE_EN
    , .hiscore(b_hs), .new_record(b_nr)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void nxt(input bit rs, input bit go, input int s, input int c, input int m,
                              input int nh, input int nm, input int smax, input int cmax,
                              output int so, output int co, output int mo);
    so = s; co = c; mo = m;
    if (rs) begin
      so = 0; co = 0; mo = 1;
    end else if (!go) begin
      so = s + nh * m;
      if (so > smax) so = smax;
      co = (nm > 0) ? 0 : c + nh;
      if (co > cmax) co = cmax;
      mo = 1 + co / 10;
      if (mo > 4) mo = 4;
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] m_hp, m_mp, m_hr, m_mr;
  int m_nh, m_nm;
  int ma_s, ma_c, ma_m, mb_s, mb_c, mb_m, na_s, na_c, na_m, nb_s, nb_c, nb_m;
  int ma_since, mb_since;
  bit ma_chg, mb_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hp <= '1; m_mp <= '1;
      ma_s <= 0; ma_c <= 0; ma_m <= 1;
      mb_s <= 0; mb_c <= 0; mb_m <= 1;
      ma_chg <= 0; mb_chg <= 0;
      ma_since <= 1000; mb_since <= 1000;
    end else begin
      m_hr = hit & ~m_hp;
      m_mr = miss & ~m_mp;
      m_nh = $countones(m_hr & ~m_mr);
      m_nm = $countones(m_mr);
      m_hp <= hit;
      m_mp <= miss;
      nxt(restart, game_over, ma_s, ma_c, ma_m, m_nh, m_nm, 65535, 255, na_s, na_c, na_m);
      nxt(restart, game_over, mb_s, mb_c, mb_m, m_nh, m_nm, 255, 15, nb_s, nb_c, nb_m);
      ma_chg   <= (na_s != ma_s);
      mb_chg   <= (nb_s != mb_s);
      ma_since <= (na_s != ma_s) ? 0 : ((ma_since < 1000) ? ma_since + 1 : ma_since);
      mb_since <= (nb_s != mb_s) ? 0 : ((mb_since < 1000) ? mb_since + 1 : mb_since);
      ma_s <= na_s; ma_c <= na_c; ma_m <= na_m;
      mb_s <= nb_s; mb_c <= nb_c; mb_m <= nb_m;
    end
  end

`ifdef SCORE_KEEPER_HISCORE_EN
  int ma_hs, mb_hs;
  bit ma_nr, mb_nr, m_go_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_hs <= 0; mb_hs <= 0; ma_nr <= 0; mb_nr <= 0; m_go_q <= 0;
    end else begin
      m_go_q <= game_over;
      ma_nr  <= 0;
      mb_nr  <= 0;
      if (game_over && !m_go_q && ma_s > ma_hs) begin ma_hs <= ma_s; ma_nr <= 1; end
      if (game_over && !m_go_q && mb_s > mb_hs) begin mb_hs <= mb_s; mb_nr <= 1; end
    end
  end
`endif

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_score", a_score, ma_s);
      chk("a_combo", a_combo, ma_c);
      chk("a_mult",  a_mult,  ma_m);
      chk("b_score", b_score, mb_s);
      chk("b_combo", b_combo, mb_c);
      chk("b_mult",  b_mult,  mb_m);
      if (a_valid) chk("a_bcd_when_valid", a_bcd, to_bcd(ma_s));
      if (b_valid) chk("b_bcd_when_valid", b_bcd, to_bcd(mb_s) & 20'hfff);
      if (ma_chg) chk("a_valid_drop", a_valid, 0);
      if (mb_chg) chk("b_valid_drop", b_valid, 0);
      if (ma_since >= 40) chk("a_valid_settle", a_valid, 1);
      if (mb_since >= 40) chk("b_valid_settle", b_valid, 1);
`ifdef SCORE_KEEPER_HISCORE_EN
      chk("a_hiscore", a_hs, ma_hs);
      chk("a_new_record", a_nr, ma_nr);
      chk("b_hiscore", b_hs, mb_hs);
      chk("b_new_record", b_nr, mb_nr);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] h, input logic [7:0] m);
    hit = h; miss = m;
    tick(1);
    hit = '0; miss = '0;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; restart = 1'b0; game_over = 1'b0; hit = '0; miss = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_score", a_score, 0);
    chk("rst_combo", a_combo, 0);
    chk("rst_mult",  a_mult, 1);
    chk("rst_bcd",   a_bcd, 0);
    chk("rst_valid", a_valid, 1);

    // held hit counts once; BCD lands SCORE_W+3 edges after the score edge
    hit = 8'h01;
    tick(1);
    chk("t1_score", a_score, 1);
    chk("t1_combo", a_combo, 1);
    chk("t1_mult",  a_mult, 1);
    tick(2);
    hit = '0;
    chk("t1_score_once", a_score, 1);
    tick(16);
    chk("t1_valid_e18", a_valid, 0);
    tick(1);
    chk("t1_valid_e19", a_valid, 1);
    chk("t1_bcd_e19", a_bcd, 20'h00001);

    // multiplier step after 10 hits
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("rs_score", a_score, 0);
    for (int i = 1; i <= 11; i++) begin
      pulse(8'h02, 8'h00);
      if (i == 10) begin
        chk("t2_combo10", a_combo, 10);
        chk("t2_mult10", a_mult, 2);
        chk("t2_score10", a_score, 10);
      end
    end
    chk("t2_score11", a_score, 12);
    chk("t2_combo11", a_combo, 11);
    chk("t2_mult11", a_mult, 2);

    // lane conflict: lane 2 hit+miss is a miss only
    pulse(8'b1000_1101, 8'b0000_0100);
    chk("t3_score", a_score, 18);
    chk("t3_combo", a_combo, 0);
    chk("t3_mult", a_mult, 1);

    // saturation on both instances
    for (int i = 0; i < 2100; i++) pulse(8'hff, 8'h00);
    chk("t4_a_score", a_score, 16'hffff);
    chk("t4_a_combo", a_combo, 255);
    chk("t4_a_mult", a_mult, 4);
    chk("t4_b_score", b_score, 255);
    chk("t4_b_combo", b_combo, 15);
    chk("t4_b_mult", b_mult, 2);
    pulse(8'hff, 8'h00);
    chk("t4_b_score_hold", b_score, 255);
    chk("t4_b_combo_hold", b_combo, 15);
    tick(45);
    chk("t4_a_bcd", a_bcd, 20'h65535);
    chk("t4_a_valid", a_valid, 1);
    chk("t4_b_bcd", b_bcd, 12'h255);
    chk("t4_b_valid", b_valid, 1);

    // game_over freeze, restart, hiscore retention
    game_over = 1'b1; tick(1); game_over = 1'b0; tick(1);
`ifdef SCORE_KEEPER_HISCORE_EN
    chk("t5_hiscore_set", a_hs, 16'hffff);
`endif
    restart = 1'b1; tick(1); restart = 1'b0;
    for (int i = 0; i < 3; i++) pulse(8'h10, 8'h00);
    chk("t5_score3", a_score, 3);
    game_over = 1'b1; tick(1);
    for (int i = 0; i < 3; i++) pulse(8'h0f, 8'h30);
    chk("t5_go_score", a_score, 3);
    chk("t5_go_combo", a_combo, 3);
    chk("t5_go_mult", a_mult, 1);
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("t5_rs_score", a_score, 0);
    chk("t5_rs_combo", a_combo, 0);
    chk("t5_rs_mult", a_mult, 1);
    game_over = 1'b0; tick(1);
`ifdef SCORE_KEEPER_HISCORE_EN
    chk("t5_hiscore_kept", a_hs, 16'hffff);
`endif

    // two score changes during SHIFT: first result written, then one more conversion
    tick(45);
    hit = 8'h20; tick(1); hit = '0;   // E0: score 1
    tick(4);
    hit = 8'h40; tick(1); hit = '0;   // E5: score 2
    tick(3);
    hit = 8'h40; tick(1); hit = '0;   // E9: score 3
    tick(10);
    chk("t6_bcd_first", a_bcd, 20'h00001);
    chk("t6_valid_first", a_valid, 0);
    tick(18);
    chk("t6_valid_e37", a_valid, 0);
    tick(1);
    chk("t6_valid_e38", a_valid, 1);
    chk("t6_bcd_final", a_bcd, 20'h00003);

    // reset mid-SHIFT, hit held across release
    tick(45);
    hit = 8'h01; tick(1); hit = '0;
    tick(6);
    hit = 8'h01;
    rst_n = 1'b0;
    #1;
    chk("t7_score", a_score, 0);
    chk("t7_bcd", a_bcd, 0);
    chk("t7_valid", a_valid, 1);
    chk("t7_mult", a_mult, 1);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("t7_held_score", a_score, 0);
    chk("t7_held_combo", a_combo, 0);
    hit = '0;
    tick(2);

    // randomized bursts with idle gaps so conversions can settle
    for (int blk = 0; blk < 40; blk++) begin
      for (int c = 0; c < 60; c++) begin
        hit  = 8'($urandom) & 8'($urandom);
        miss = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        if ($urandom_range(0, 29) == 0) game_over = ~game_over;
        restart = ($urandom_range(0, 79) == 0);
        tick(1);
      end
      hit = '0; miss = '0; restart = 1'b0; game_over = 1'b0;
      tick(45);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
